// File: rtl/mem_read_streamer.sv
// Burst read initiator for a 1R1W memory: issues one read address per cycle,
// absorbs the 1-cycle read latency and streams words out through a 2-entry buffer.
module mem_read_streamer #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH+1)'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   remain_q, remain_d;
    logic                  inflight_q, inflight_d;
    logic                  inflightLast_q, inflightLast_d;
    logic                  done_q, done_d;
    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] fifoData_q [2];
    logic [1:0]            fifoLast_q;
    logic                  wrPtr_q, rdPtr_q;

    logic cmdFire, issue, push, pop, popLast, lastIssue;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmdFire && cmd_len != '0) state_d = RUN;
            RUN:     if (lastIssue) state_d = DRAIN;
            DRAIN:   if (popLast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A read may issue only if the word it returns is guaranteed a buffer slot.
    always_comb begin
        cmd_ready = (state_q == IDLE);
        out_valid = (occ_q != 2'd0);
        out_data  = fifoData_q[rdPtr_q];
        out_last  = out_valid && fifoLast_q[rdPtr_q];
        raddr     = addr_q;
        done      = done_q;
        cmdFire   = cmd_valid && cmd_ready;
        pop       = out_valid && out_ready;
        popLast   = pop && fifoLast_q[rdPtr_q];
        push      = inflight_q;
        issue     = (state_q == RUN) &&
                    (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
        lastIssue = issue && (remain_q == LEN_ONE);
    end

    always_comb begin
        addr_d   = addr_q;
        remain_d = remain_q;
        if (cmdFire) begin
            addr_d   = cmd_base;
            remain_d = cmd_len;
        end else if (issue) begin
            addr_d   = addr_q + ADDR_WIDTH'(1);
            remain_d = remain_q - LEN_ONE;
        end
        inflight_d     = issue;
        inflightLast_d = lastIssue;
        done_d         = (cmdFire && cmd_len == '0) || popLast;
        occ_d          = occ_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q         <= '0;
            remain_q       <= '0;
            inflight_q     <= 1'b0;
            inflightLast_q <= 1'b0;
            done_q         <= 1'b0;
            occ_q          <= 2'd0;
        end else begin
            addr_q         <= addr_d;
            remain_q       <= remain_d;
            inflight_q     <= inflight_d;
            inflightLast_q <= inflightLast_d;
            done_q         <= done_d;
            occ_q          <= occ_d;
        end
    end

    // The word read last cycle lands in the buffer now, with its end-of-burst tag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                fifoData_q[i] <= '0;
            end
            fifoLast_q <= 2'b00;
            wrPtr_q    <= 1'b0;
            rdPtr_q    <= 1'b0;
        end else begin
            if (push) begin
                fifoData_q[wrPtr_q] <= rdata;
                fifoLast_q[wrPtr_q] <= inflightLast_q;
                wrPtr_q             <= ~wrPtr_q;
            end
            if (pop) begin
                rdPtr_q <= ~rdPtr_q;
            end
        end
    end

endmodule
